// File: rtl/botao_evento.sv
// Press-gesture classifier: turns controller press pulses plus the button level
// into one-cycle single/double/long events. Double-click support needs DOUBLE_CLICK_EN.
module botao_evento #(
  parameter int CNT_W       = 24,
  parameter int LONG_CYCLES = 12000000,
  parameter int DOUBLE_GAP  = 6000000
) (
  input  logic clk,
  input  logic rst,
  input  logic b_pulse,
  input  logic b_level,
  output logic ev_single,
  output logic ev_double,
  output logic ev_long,
  output logic busy
);

  localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  // Out-of-range timing parameters are a configuration error.
  if (CNT_W < 2 || CNT_W > 62) begin : g_bad_cnt_w
    $error("botao_evento: CNT_W=%0d out of range", CNT_W);
  end
  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > MAX_CNT) begin : g_bad_long
    $error("botao_evento: LONG_CYCLES=%0d out of range", LONG_CYCLES);
  end
  if (DOUBLE_GAP < 2 || longint'(DOUBLE_GAP) > MAX_CNT) begin : g_bad_gap
    $error("botao_evento: DOUBLE_GAP=%0d out of range", DOUBLE_GAP);
  end

`ifdef DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DOUBLE_GAP - 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    WAIT2   = 2'd2,
    HELD    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             single_nxt;
  logic             double_nxt;
  logic             long_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ev_single <= 1'b0;
      ev_double <= 1'b0;
      ev_long   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ev_single <= single_nxt;
      ev_double <= double_nxt;
      ev_long   <= long_nxt;
    end
  end

  // Counter is cleared on every state entry, so equality before increment never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (b_pulse) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        if (!b_level) begin
`ifdef DOUBLE_CLICK_EN
          state_nxt = WAIT2;
`else
          state_nxt = IDLE;
`endif
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
`ifdef DOUBLE_CLICK_EN
      WAIT2: begin
        if (b_pulse) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
`endif
      HELD: begin
        if (!b_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Event decode mirrors the transitions above; a press in WAIT2 outranks the timeout.
  always_comb begin
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = (state == PRESSED) && b_level && (cnt == LONG_LAST);
`ifdef DOUBLE_CLICK_EN
    double_nxt = (state == WAIT2) && b_pulse;
    single_nxt = (state == WAIT2) && !b_pulse && (cnt == GAP_LAST);
`else
    single_nxt = (state == PRESSED) && !b_level;
`endif
  end

  assign busy = (state != IDLE);

endmodule
